alu_input_sequencer: RTL and testbench

ALU_INPUT_SEQUENCER -- requirements
Module: alu_input_sequencer

---
 rtl/alu_seq_pkg.sv | 21 ++
 rtl/alu_input_sequencer_if.sv | 34 +++
 rtl/btn_step_sync.sv | 35 +++
 rtl/alu_input_sequencer.sv | 107 ++++++++++
 tb/tb_alu_input_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU input sequencer.
// Holds the FSM state encoding, opcode values and default operand width.
package alu_seq_pkg;

   localparam int N_DEFAULT = 4;

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_SHOW = 3'd4
   } state_t;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_XOR = 3'd2;
   localparam logic [2:0] OP_SHR = 3'd3;
   localparam logic [2:0] OP_SHL = 3'd4;

endpackage

// File: rtl/alu_input_sequencer_if.sv
// Board-side and ALU-side signals of the sequencer, grouped for one port.
// master = sequencer view, slave = board/ALU/testbench view.
interface alu_input_sequencer_if #(parameter int N = alu_seq_pkg::N_DEFAULT);

   logic [N-1:0] sw;
   logic [2:0]   op_sw;
   logic         btn;
   logic         clr;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] r_and;
   logic [N-1:0] r_or;
   logic [N-1:0] r_xor;
   logic [N-1:0] r_shiftR;
   logic [N-1:0] r_shiftL;
   logic [N-1:0] result;
   logic [2:0]   op;
   logic [2:0]   state_o;
   logic         valid;
   logic         zero;
   logic         neg;
   logic         err;

   modport master (
      input  sw, op_sw, btn, clr, r_and, r_or, r_xor, r_shiftR, r_shiftL,
      output a, b, op, result, state_o, valid, zero, neg, err
   );

   modport slave (
      output sw, op_sw, btn, clr, r_and, r_or, r_xor, r_shiftR, r_shiftL,
      input  a, b, op, result, state_o, valid, zero, neg, err
   );

endinterface

// File: rtl/btn_step_sync.sv
// Button synchronizer + rising-edge detector: one-cycle step, 2 cycles after btn rises.
// Stays disarmed after reset until the synchronized button has been seen low.
module btn_step_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic step
);

   logic sync1, sync2, prev;
   logic warm1, warm2, armed;

   // warm1/warm2 hold off arming until sync2 reflects the real button,
   // so a button held through reset release cannot masquerade as a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
         warm1 <= 1'b0;
         warm2 <= 1'b0;
         armed <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         prev  <= sync2;
         warm1 <= 1'b1;
         warm2 <= warm1;
         armed <= armed | (warm2 & ~sync2);
      end
   end

   assign step = sync2 & ~prev & armed;

endmodule

// File: rtl/alu_input_sequencer.sv
// Steps a, b and opcode in from switches, then latches the opcode-selected external ALU result.
// State advances on the 3rd clk edge after a button press; clr aborts to S_A on the next edge.
module alu_input_sequencer
   import alu_seq_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   alu_input_sequencer_if.master   bus
);

   state_t       state, state_nxt;
   logic         step;
   logic         load_a, load_b, load_op, latch, clear;
   logic [N-1:0] a_q, b_q, result_q, sel;
   logic [2:0]   op_q;
   logic         valid_q, zero_q, neg_q, err_q, sel_err;

   btn_step_sync u_step (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (bus.btn),
      .step  (step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_A;
      else        state <= state_nxt;
   end

   // clr outranks any step arriving in the same cycle
   always_comb begin
      state_nxt = state;
      load_a    = 1'b0;
      load_b    = 1'b0;
      load_op   = 1'b0;
      latch     = 1'b0;
      clear     = 1'b0;
      if (bus.clr) begin
         state_nxt = S_A;
         clear     = 1'b1;
      end else begin
         case (state)
            S_A:    if (step) begin load_a  = 1'b1; state_nxt = S_B;    end
            S_B:    if (step) begin load_b  = 1'b1; state_nxt = S_OP;   end
            S_OP:   if (step) begin load_op = 1'b1; state_nxt = S_EXEC; end
            S_EXEC: begin latch = 1'b1; state_nxt = S_SHOW; end
            S_SHOW: if (step) state_nxt = S_A;
            default: state_nxt = S_A;
         endcase
      end
   end

   always_comb begin
      sel     = '0;
      sel_err = 1'b0;
      case (op_q)
         OP_AND:  sel = bus.r_and;
         OP_OR:   sel = bus.r_or;
         OP_XOR:  sel = bus.r_xor;
         OP_SHR:  sel = bus.r_shiftR;
         OP_SHL:  sel = bus.r_shiftL;
         default: sel_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (load_a)  a_q  <= bus.sw;
         if (load_b)  b_q  <= bus.sw;
         if (load_op) op_q <= bus.op_sw;
         if (clear) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
         end else if (latch) begin
            result_q <= sel;
            zero_q   <= (sel == '0);
            neg_q    <= sel[N-1];
            err_q    <= sel_err;
         end
         valid_q <= (state_nxt == S_SHOW);
      end
   end

   assign bus.a       = a_q;
   assign bus.b       = b_q;
   assign bus.op      = op_q;
   assign bus.result  = result_q;
   assign bus.state_o = state;
   assign bus.valid   = valid_q;
   assign bus.zero    = zero_q;
   assign bus.neg     = neg_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Randomized scoreboard bench for alu_input_sequencer with a behavioural ALU model.
module tb_alu_input_sequencer;
   import alu_seq_pkg::*;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_input_sequencer_if #(.N(N)) bus();

   alu_input_sequencer #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // External logic ALU the sequencer feeds
   assign bus.r_and    = bus.a & bus.b;
   assign bus.r_or     = bus.a | bus.b;
   assign bus.r_xor    = bus.a ^ bus.b;
   assign bus.r_shiftR = bus.a >> 1;
   assign bus.r_shiftL = bus.a << 1;

   typedef struct packed {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [2:0]   op;
      logic [N-1:0] result;
      logic         zero;
      logic         neg;
      logic         err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic valid_q = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
      exp_t e;
      int   ia = int'(a);
      int   ib = int'(b);
      int   r;
      e.a   = a;
      e.b   = b;
      e.op  = op;
      e.err = 1'b0;
      case (op)
         3'd0:    r = ia & ib;
         3'd1:    r = ia | ib;
         3'd2:    r = ia ^ ib;
         3'd3:    r = ia / 2;
         3'd4:    r = (ia * 2) % (1 << N);
         default: begin r = 0; e.err = 1'b1; end
      endcase
      e.result = r[N-1:0];
      e.zero   = (r == 0);
      e.neg    = (r >= (1 << (N - 1)));
      return e;
   endfunction

   // Monitor: one scoreboard entry per entry into S_SHOW
   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus.valid && !valid_q) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("sb_result", bus.result, e.result);
            check("sb_flags", {bus.zero, bus.neg, bus.err}, {e.zero, e.neg, e.err});
            check("sb_operands", {bus.a, bus.b, bus.op}, {e.a, e.b, e.op});
         end
      end
      valid_q = bus.valid;
   end

   task automatic press(input logic [N-1:0] s, input logic [2:0] o, input int hold);
      bus.sw    = s;
      bus.op_sw = o;
      bus.btn   = 1'b1;
      repeat (hold) @(negedge clk);
      bus.btn = 1'b0;
      repeat (4) @(negedge clk);
      bus.sw    = N'($urandom_range((1 << N) - 1, 0));
      bus.op_sw = 3'($urandom_range(7, 0));
   endtask

   task automatic do_seq(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op, input int hold);
      press(a, 3'($urandom_range(7, 0)), hold);
      check("state_after_a", bus.state_o, 32'(S_B));
      press(b, 3'($urandom_range(7, 0)), hold);
      check("state_after_b", bus.state_o, 32'(S_OP));
      exp_q.push_back(model(a, b, op));
      press(N'($urandom_range((1 << N) - 1, 0)), op, hold);
      check("show_state_valid", {bus.state_o, bus.valid}, {3'(S_SHOW), 1'b1});
   endtask

   task automatic leave_show(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
      exp_t e = model(a, b, op);
      press(N'($urandom_range((1 << N) - 1, 0)), 3'($urandom_range(7, 0)), $urandom_range(1, 5));
      check("leave_state_valid", {bus.state_o, bus.valid}, {3'(S_A), 1'b0});
      check("leave_hold", {bus.a, bus.b, bus.op, bus.result, bus.zero, bus.neg, bus.err},
            {a, b, op, e.result, e.zero, e.neg, e.err});
   endtask

   task automatic pulse_clr();
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      @(negedge clk);
   endtask

   initial begin : stimulus
      int trans;
      logic [2:0] last;
      logic [N-1:0] ra, rb;
      logic [2:0] rop;

      bus.btn = 1'b0; bus.clr = 1'b0; bus.sw = '0; bus.op_sw = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {bus.a, bus.b, bus.op, bus.result, bus.state_o, bus.valid, bus.zero, bus.neg, bus.err}, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Directed: and, xor, illegal opcode
      do_seq(4'b1010, 4'b0110, 3'b000, 2);
      leave_show(4'b1010, 4'b0110, 3'b000);
      do_seq(4'b1010, 4'b0110, 3'b010, 3);
      leave_show(4'b1010, 4'b0110, 3'b010);
      do_seq(4'b1010, 4'b0110, 3'b111, 1);
      leave_show(4'b1010, 4'b0110, 3'b111);

      // Reset mid-sequence in S_B
      press(4'b0011, 3'd0, 2);
      check("pre_reset_state", bus.state_o, 32'(S_B));
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {bus.a, bus.b, bus.op, bus.result, bus.state_o, bus.valid, bus.zero, bus.neg, bus.err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      press(4'b0101, 3'd0, 2);
      check("post_reset_load_a", {bus.a, bus.state_o}, {4'b0101, 3'(S_B)});
      pulse_clr();
      check("clr_from_s_b", bus.state_o, 32'(S_A));

      // clr coinciding with a step pulse while in S_SHOW
      do_seq(4'b1001, 4'b0011, 3'b001, 2);
      bus.btn = 1'b1;
      repeat (2) @(negedge clk);
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      check("clr_step_state_valid", {bus.state_o, bus.valid}, {3'(S_A), 1'b0});
      check("clr_step_cleared", {bus.result, bus.zero, bus.neg, bus.err}, 32'd0);
      check("clr_step_a_kept", bus.a, 4'b1001);
      bus.btn = 1'b0;
      repeat (4) @(negedge clk);
      press(4'b0010, 3'd0, 1);
      check("after_clr_loads_a", {bus.a, bus.state_o}, {4'b0010, 3'(S_B)});
      pulse_clr();

      // Held button: exactly one transition
      bus.btn = 1'b1;
      trans = 0;
      last = bus.state_o;
      repeat (24) begin
         @(negedge clk);
         if (bus.state_o != last) trans++;
         last = bus.state_o;
      end
      check("held_btn_transitions", trans, 32'd1);
      check("held_btn_state", bus.state_o, 32'(S_B));
      bus.btn = 1'b0;
      repeat (4) @(negedge clk);
      check("release_no_step", bus.state_o, 32'(S_B));
      pulse_clr();

      // Button held through reset release
      bus.btn = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("btn_held_thru_reset", bus.state_o, 32'(S_A));
      bus.btn = 1'b0;
      repeat (4) @(negedge clk);
      press(4'b0110, 3'd0, 2);
      check("repress_after_reset", {bus.a, bus.state_o}, {4'b0110, 3'(S_B)});
      pulse_clr();

      // Randomized sequences
      for (int i = 0; i < 25; i++) begin
         ra  = N'($urandom_range((1 << N) - 1, 0));
         rb  = N'($urandom_range((1 << N) - 1, 0));
         rop = 3'($urandom_range(7, 0));
         do_seq(ra, rb, rop, $urandom_range(1, 6));
         leave_show(ra, rb, rop);
      end

      repeat (5) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
